// File: rtl/test_sequencer.sv
// test_sequencer: run controller for the output checkers and the compiled core.
// Walks test cases 0..NUM_CASES-1. For each case it holds the datapath in
// reset for two cycles, releases it, watches every checker's complete flag
// until all are set or the cycle budget runs out, then tallies pass/fail.
//
// Optional feature macro: TESTSEQ_STEP_EN
//   When defined, adds a 'step' input and a 'paused' output. After checking a
//   non-final case the sequencer parks in PAUSE (datapath held in reset) until
//   a step pulse starts the next case.
//
// start and step are captured into a flop only while they can be honoured,
// which gives the three-edge start-to-release latency: capture edge, then two
// edges of datapath reset hold.

module test_sequencer #(
  parameter int NUM_OUT   = 2,
  parameter int NUM_CASES = 5,
  parameter int CASE_W    = 4,
  parameter int TIMEOUT   = 100000,
  parameter int CYC_W     = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_OUT-1:0]     complete,
  input  logic [6*NUM_OUT-1:0]   errors,
`ifdef TESTSEQ_STEP_EN
  input  logic                   step,
  output logic                   paused,
`endif
  output logic                   dp_rst,
  output logic [CASE_W-1:0]      case_idx,
  output logic                   running,
  output logic [CYC_W-1:0]       cycles,
  output logic [CASE_W:0]        pass_count,
  output logic [CASE_W:0]        fail_count,
  output logic                   timed_out,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_CHECK,
    S_DONE,
    S_PAUSE
  } state_t;

  localparam logic [CASE_W-1:0] LAST_CASE    = CASE_W'(NUM_CASES - 1);
  localparam logic [CYC_W-1:0]  TIMEOUT_CYC  = CYC_W'(TIMEOUT);
  localparam logic [CYC_W-1:0]  TIMEOUT_LAST = CYC_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                hold_q, hold_d;
  logic                start_q, start_d;
  logic                dp_rst_q, dp_rst_d;
  logic [CASE_W-1:0]   case_idx_q, case_idx_d;
  logic                running_q, running_d;
  logic [CYC_W-1:0]    cycles_q, cycles_d;
  logic [CASE_W:0]     pass_count_q, pass_count_d;
  logic [CASE_W:0]     fail_count_q, fail_count_d;
  logic                timed_out_q, timed_out_d;
  logic                done_q, done_d;
`ifdef TESTSEQ_STEP_EN
  logic                step_q, step_d;
  logic                paused_q, paused_d;
`endif

  logic all_complete;
  logic errors_clean;
  logic case_passed;

  assign all_complete = &complete;
  assign errors_clean = (errors == '0);
  assign case_passed  = !timed_out_q && errors_clean;

  // Next-state and next-output logic for the run controller.
  always_comb begin
    // NOTE: every value driven here gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    hold_d       = hold_q;
    case_idx_d   = case_idx_q;
    cycles_d     = cycles_q;
    pass_count_d = pass_count_q;
    fail_count_d = fail_count_q;
    timed_out_d  = timed_out_q;

    // Capture start only where it is honoured, so a press during a case or
    // during the final CHECK cannot leak into DONE.
    start_d = start && ((state_q == S_IDLE) || (state_q == S_DONE));
`ifdef TESTSEQ_STEP_EN
    step_d  = step && (state_q == S_PAUSE);
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_q) begin
          state_d      = S_RESET;
          hold_d       = 1'b0;
          case_idx_d   = '0;
          pass_count_d = '0;
          fail_count_d = '0;
          timed_out_d  = 1'b0;
        end
      end

      S_RESET: begin
        // Two cycles of datapath reset, counted by the 1-bit hold flag.
        if (hold_q) begin
          state_d  = S_RUN;
          cycles_d = '0;
        end else begin
          hold_d = 1'b1;
        end
      end

      S_RUN: begin
        if (cycles_q != TIMEOUT_CYC) begin
          cycles_d = cycles_q + 1'b1;
        end
        // Completion is tested first so it wins over a same-cycle timeout.
        if (all_complete) begin
          state_d     = S_CHECK;
          timed_out_d = 1'b0;
        end else if (cycles_q == TIMEOUT_LAST) begin
          state_d     = S_CHECK;
          timed_out_d = 1'b1;
        end
      end

      S_CHECK: begin
        if (case_passed) begin
          pass_count_d = pass_count_q + 1'b1;
        end else begin
          fail_count_d = fail_count_q + 1'b1;
        end
        if (case_idx_q == LAST_CASE) begin
          state_d = S_DONE;
        end else begin
          case_idx_d = case_idx_q + 1'b1;
          hold_d     = 1'b0;
`ifdef TESTSEQ_STEP_EN
          state_d    = S_PAUSE;
`else
          state_d    = S_RESET;
`endif
        end
      end

`ifdef TESTSEQ_STEP_EN
      S_PAUSE: begin
        if (step_q) begin
          state_d = S_RESET;
          hold_d  = 1'b0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered versions of what the next state implies. The
    // datapath stays out of reset through CHECK so error counts are still
    // valid while they are judged; reset rises on CHECK exit.
    dp_rst_d  = !((state_d == S_RUN) || (state_d == S_CHECK));
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
`ifdef TESTSEQ_STEP_EN
    paused_d  = (state_d == S_PAUSE);
`endif
  end

  // State and registered outputs; async reset returns everything to idle
  // with the datapath held in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hold_q       <= 1'b0;
      start_q      <= 1'b0;
      dp_rst_q     <= 1'b1;
      case_idx_q   <= '0;
      running_q    <= 1'b0;
      cycles_q     <= '0;
      pass_count_q <= '0;
      fail_count_q <= '0;
      timed_out_q  <= 1'b0;
      done_q       <= 1'b0;
`ifdef TESTSEQ_STEP_EN
      step_q       <= 1'b0;
      paused_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      hold_q       <= hold_d;
      start_q      <= start_d;
      dp_rst_q     <= dp_rst_d;
      case_idx_q   <= case_idx_d;
      running_q    <= running_d;
      cycles_q     <= cycles_d;
      pass_count_q <= pass_count_d;
      fail_count_q <= fail_count_d;
      timed_out_q  <= timed_out_d;
      done_q       <= done_d;
`ifdef TESTSEQ_STEP_EN
      step_q       <= step_d;
      paused_q     <= paused_d;
`endif
    end
  end

  assign dp_rst     = dp_rst_q;
  assign case_idx   = case_idx_q;
  assign running    = running_q;
  assign cycles     = cycles_q;
  assign pass_count = pass_count_q;
  assign fail_count = fail_count_q;
  assign timed_out  = timed_out_q;
  assign done       = done_q;
`ifdef TESTSEQ_STEP_EN
  assign paused     = paused_q;
`endif

endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
Run controller for the output checkers and the compiled core.
- Walks test cases 0..NUM_CASES-1.
- For each case: holds the datapath (core, input streams, output checkers) in reset, releases it and watches every checker's complete flag.
- Ends the case on completion or on a cycle timeout, then tallies pass/fail.
- Sits between the board-level start button and the per-case stream data ROM selector.

Parameters:
NUM_OUT, 2, number of output checkers monitored
NUM_CASES, 5, number of test cases per run
CASE_W, 4, width of case index (2^CASE_W >= NUM_CASES)
TIMEOUT, 100000, max cycles per case before it is declared failed
CYC_W, 20, cycle counter width (2^CYC_W > TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  begin a run; honoured only in IDLE or DONE
complete  in  NUM_OUT  per-checker complete flags
errors  in  6*NUM_OUT  packed checker error counts, checker i at [6i+5:6i]
dp_rst  out  1  registered reset to core/streams/checkers, active-high
case_idx  out  CASE_W  selects current case's stream data
running  out  1  high while in RUN
cycles  out  CYC_W  cycles elapsed in current case, saturates at TIMEOUT
pass_count  out  CASE_W+1  cases passed this run
fail_count  out  CASE_W+1  cases failed this run
timed_out  out  1  last checked case ended by timeout
done  out  1  run finished

Behaviour:
- Reset values: dp_rst=1; all other outputs 0; state IDLE.
- All outputs are registered.
- IDLE:
  - dp_rst=1.
  - start=1 -> RESET; clear pass_count, fail_count, case_idx, timed_out.
- RESET:
  - dp_rst=1 for exactly 2 cycles (internal 1-bit hold counter), then -> RUN.
  - On entry to RUN: dp_rst=0, cycles=0, running=1.
  - Start sampled at edge t -> dp_rst falls at edge t+3.
- RUN:
  - cycles increments every cycle.
  - All complete bits high -> CHECK with timed_out=0.
  - Else if cycles == TIMEOUT-1 -> CHECK with timed_out=1; cycles reads TIMEOUT.
  - Completion and timeout on the same cycle: completion wins.
  - running=0 on exit.
- CHECK (1 cycle):
  - Pass means timed_out==0 and every errors slice is zero; increment pass_count, else fail_count.
  - dp_rst=1 on exit so checkers clear.
  - If case_idx==NUM_CASES-1 -> DONE; else case_idx+1 -> RESET.
- DONE:
  - done=1, dp_rst=1.
  - Counts and case_idx hold.
  - start -> RESET with counts cleared, done=0.
- start is ignored in RESET, RUN and CHECK.
- complete and errors are ignored outside RUN/CHECK.
- Invariant: pass_count+fail_count == number of cases checked.
- Async rst mid-run: immediate return to reset values, including dp_rst=1.

Optional Feature:
TESTSEQ_STEP_EN
- Defined:
  - Adds input step (1 bit) and output paused (1 bit).
  - After CHECK of a non-final case, enter PAUSE: paused=1, dp_rst=1.
  - step pulse -> RESET for the next case.
  - start is ignored in PAUSE.
- Undefined: no step/paused ports; CHECK proceeds directly to RESET.

Test Plan:
All scenarios use NUM_OUT=2, NUM_CASES=3, TIMEOUT=50.
1. rst pulse -> dp_rst=1, done=0, counts 0. Start at cycle 10 -> dp_rst=0 at cycle 13, running=1, case_idx=0.
2. Each case: complete=2'b11 after 20 RUN cycles, errors=0 -> pass_count=3, fail_count=0, done=1, cycles=20 while in CHECK.
3. Case 1: checker 1 errors=6'd4 -> pass_count=2, fail_count=1, timed_out=0.
4. Case 0: complete stuck at 2'b01 -> cycles reaches 50, timed_out=1, fail_count=1, case_idx advances to 1.
5. complete=2'b11 on the same cycle cycles==49 -> pass, timed_out=0. Start asserted mid-RUN -> no effect. Start in DONE -> counts cleared, new run.
6. TESTSEQ_STEP_EN: after case 0, paused=1 held 100 cycles. step pulse -> dp_rst deasserts 3 cycles later with case_idx=1. No PAUSE after the final case.
